game_sequencer: RTL

Game controller that sequences the batting unit and owns all game state. It raises and drops the batting unit's `start` level on pitch/stop requests, then consumes the one-cycle `hit_pulse`/`out_pulse` result. It tracks base runners, outs, half-inning, inning and both scores, and decides side changes, extra innings and game end. It sits between the player buttons, the batting unit and the scoreboard display.

---
 rtl/game_sequencer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: game controller for the batting game.
//
// Sequences the batting unit (bat_start level), consumes its one-cycle result pulses, and owns
// all game state: base runners, outs, half-inning, inning, both scores, side changes, extra
// innings and game end.
//
// Parameters:
//   INNINGS  regulation innings (1..15)
//   SCORE_W  score counter width
//   TIMEOUT  max cycles spent waiting for a result before aborting the pitch (>= 2)
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous active-high reset
//   game_start    start a fresh game (idle / game over only)
//   pitch         request a pitch (ready only)
//   stop          player swing (swing only)
//   hit_pulse     {hit1,hit2,hit3,hit4} from the batting unit, one cycle
//   out_pulse     batter out from the batting unit, one cycle
//   bat_start     level to the batting unit start input
//   bases         {3rd,2nd,1st} occupancy
//   outs          outs in the current half-inning
//   inning        current inning, 1-based (0 after reset)
//   top           1 = visitors batting
//   score_top     visitor runs
//   score_bottom  home runs
//   game_over     high while the game is over
//   fault         one-cycle pulse when a result wait times out
module game_sequencer #(
  parameter int unsigned INNINGS = 9,
  parameter int unsigned SCORE_W = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_start,
  input  logic               pitch,
  input  logic               stop,
  input  logic [3:0]         hit_pulse,
  input  logic               out_pulse,
  output logic               bat_start,
  output logic [2:0]         bases,
  output logic [1:0]         outs,
  output logic [3:0]         inning,
  output logic               top,
  output logic [SCORE_W-1:0] score_top,
  output logic [SCORE_W-1:0] score_bottom,
  output logic               game_over,
  output logic               fault
);

  localparam int unsigned        CntW      = $clog2(TIMEOUT);
  localparam logic [CntW-1:0]    CntLast   = CntW'(TIMEOUT - 1);
  localparam logic [3:0]         InningsL  = 4'(INNINGS);
  localparam logic [3:0]         MaxInning = 4'd15;
  localparam logic [SCORE_W-1:0] ScoreMax  = '1;
  // Wide enough to hold max score plus four runs without wrapping.
  localparam int unsigned        SumW      = SCORE_W + 3;

  typedef enum logic [2:0] {
    StIdle,
    StReady,
    StSwing,
    StWait,
    StUpdate,
    StCheck,
    StOver
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         bases_q, bases_d;
  logic [1:0]         outs_q, outs_d;
  logic [3:0]         inning_q, inning_d;
  logic               top_q, top_d;
  logic [SCORE_W-1:0] score_top_q, score_top_d;
  logic [SCORE_W-1:0] score_bot_q, score_bot_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [4:0]         res_q, res_d;  // captured {hit_pulse, out_pulse}
  logic               fault_q, fault_d;

  logic               result_valid;
  logic [6:0]         adv;
  logic [2:0]         runs;
  logic [SumW-1:0]    score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic               home_ahead;
  logic               late;

  assign result_valid = $onehot({hit_pulse, out_pulse});

  // Batter joins as bit 0, then every runner advances k bases; bits 6:3 crossed home.
  always_comb begin
    adv = 7'd0;
    unique case (1'b1)
      res_q[4]: adv = {3'b000, bases_q, 1'b1};
      res_q[3]: adv = {3'b000, bases_q, 1'b1} << 1;
      res_q[2]: adv = {3'b000, bases_q, 1'b1} << 2;
      res_q[1]: adv = {3'b000, bases_q, 1'b1} << 3;
      default:  adv = 7'd0;
    endcase
  end

  assign runs = {2'b00, adv[3]} + {2'b00, adv[4]} + {2'b00, adv[5]} + {2'b00, adv[6]};

  assign score_sum = SumW'(top_q ? score_top_q : score_bot_q) + SumW'(runs);
  assign score_sat = (score_sum > SumW'(ScoreMax)) ? ScoreMax : score_sum[SCORE_W-1:0];

  assign home_ahead = score_bot_q > score_top_q;
  assign late       = inning_q >= InningsL;

  always_comb begin
    state_d     = state_q;
    bases_d     = bases_q;
    outs_d      = outs_q;
    inning_d    = inning_q;
    top_d       = top_q;
    score_top_d = score_top_q;
    score_bot_d = score_bot_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    fault_d     = 1'b0;

    unique case (state_q)
      StIdle, StOver: begin
        if (game_start) begin
          state_d     = StReady;
          bases_d     = 3'd0;
          outs_d      = 2'd0;
          inning_d    = 4'd1;
          top_d       = 1'b1;
          score_top_d = '0;
          score_bot_d = '0;
        end
      end
      StReady: begin
        if (pitch) state_d = StSwing;
      end
      StSwing: begin
        if (stop) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (result_valid) begin
          res_d   = {hit_pulse, out_pulse};
          state_d = StUpdate;
        end else if (cnt_q == CntLast) begin
          state_d = StReady;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StUpdate: begin
        state_d = StCheck;
        if (res_q[0]) begin
          outs_d = outs_q + 2'd1;
        end else begin
          bases_d = adv[2:0];
          if (top_q) score_top_d = score_sat;
          else       score_bot_d = score_sat;
        end
      end
      StCheck: begin
        state_d = StReady;
        if (!top_q && late && home_ahead) begin
          state_d = StOver;  // walk-off
        end else if (outs_q == 2'd3 && top_q) begin
          if (late && home_ahead) begin
            state_d = StOver;  // home already ahead, bottom half not played
          end else begin
            top_d   = 1'b0;
            bases_d = 3'd0;
            outs_d  = 2'd0;
          end
        end else if (outs_q == 2'd3 && !top_q) begin
          if (late && (score_bot_q != score_top_q)) begin
            state_d = StOver;
          end else if (inning_q == MaxInning) begin
            state_d = StOver;  // capped at 15 innings, ends tied
          end else begin
            inning_d = inning_q + 4'd1;
            top_d    = 1'b1;
            bases_d  = 3'd0;
            outs_d   = 2'd0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      bases_q     <= 3'd0;
      outs_q      <= 2'd0;
      inning_q    <= 4'd0;
      top_q       <= 1'b0;
      score_top_q <= '0;
      score_bot_q <= '0;
      cnt_q       <= '0;
      res_q       <= 5'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bases_q     <= bases_d;
      outs_q      <= outs_d;
      inning_q    <= inning_d;
      top_q       <= top_d;
      score_top_q <= score_top_d;
      score_bot_q <= score_bot_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      fault_q     <= fault_d;
    end
  end

  assign bat_start    = (state_q == StSwing);
  assign game_over    = (state_q == StOver);
  assign bases        = bases_q;
  assign outs         = outs_q;
  assign inning       = inning_q;
  assign top          = top_q;
  assign score_top    = score_top_q;
  assign score_bottom = score_bot_q;
  assign fault        = fault_q;

endmodule
